// File: rtl/fix_pkg.sv
// Shared types and default parameters for the fixed-point to integer stream stage.
package fix_pkg;

  localparam int unsigned DEF_WI = 8;
  localparam int unsigned DEF_WF = 32;
  localparam int unsigned DEF_WO = 6;
  localparam int unsigned DEF_CW = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/fix_sat.sv
// Combinational conversion of a signed fixed-point word to a saturated WO-bit integer.
module fix_sat #(
  parameter int unsigned WI = 8,
  parameter int unsigned WF = 32,
  parameter int unsigned WO = 6
) (
  input  logic [WI+WF-1:0] in_data,
  input  logic             in_oflag,
  output logic [WO-1:0]    out_int,
  output logic             out_sat,
  output logic             out_frac
);

  localparam logic signed [WI-1:0] MAX_I = WI'((2 ** (WO - 1)) - 1);
  localparam logic signed [WI-1:0] MIN_I = ~MAX_I;
  localparam logic [WO-1:0] MAX_O = {1'b0, {(WO - 1){1'b1}}};
  localparam logic [WO-1:0] MIN_O = {1'b1, {(WO - 1){1'b0}}};

  logic signed [WI-1:0] int_part;

  assign int_part = in_data[WI+WF-1:WF];
  assign out_frac = |in_data[WF-1:0];

  // A ceil-stage wrap always means a positive result that overflowed.
  always_comb begin
    out_int = int_part[WO-1:0];
    out_sat = 1'b0;
    if (in_oflag || (int_part > MAX_I)) begin
      out_int = MAX_O;
      out_sat = 1'b1;
    end else if (int_part < MIN_I) begin
      out_int = MIN_O;
      out_sat = 1'b1;
    end
  end

endmodule

// File: rtl/fix2int_stream.sv
// Streaming fix-to-int stage: input-side saturation, 2-entry skid buffer, saturation counter.
module fix2int_stream
  import fix_pkg::*;
#(
  parameter int unsigned WI = DEF_WI,
  parameter int unsigned WF = DEF_WF,
  parameter int unsigned WO = DEF_WO,
  parameter int unsigned CW = DEF_CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WI+WF-1:0] in_data,
  input  logic             in_oflag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WO-1:0]    out_int,
  output logic             out_sat,
  output logic             out_frac,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CW-1:0]    sat_cnt
);

  logic [WO-1:0] conv_int;
  logic          conv_sat;
  logic          conv_frac;

  logic [WO-1:0] skid_int;
  logic          skid_sat;
  logic          skid_frac;

  skid_state_t state;
  skid_state_t state_next;

  logic in_xfer;
  logic out_xfer;
  logic load_main;
  logic load_skid;
  logic promote;

  fix_sat #(.WI(WI), .WF(WF), .WO(WO)) u_sat (
    .in_data  (in_data),
    .in_oflag (in_oflag),
    .out_int  (conv_int),
    .out_sat  (conv_sat),
    .out_frac (conv_frac)
  );

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (in_xfer) state_next = ONE;
      ONE:     if (in_xfer && !out_xfer) state_next = TWO;
               else if (!in_xfer && out_xfer) state_next = EMPTY;
      TWO:     if (out_xfer) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Datapath load strobes for the presented entry and the skid entry.
  always_comb begin
    load_main = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    case (state)
      EMPTY:   load_main = in_xfer;
      ONE: begin
        load_main = in_xfer & out_xfer;
        load_skid = in_xfer & ~out_xfer;
      end
      TWO:     promote = out_xfer;
      default: ;
    endcase
  end

  // in_ready comes from the next state so it never sees out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next != TWO);
      out_valid <= (state_next != EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_int   <= '0;
      out_sat   <= 1'b0;
      out_frac  <= 1'b0;
      skid_int  <= '0;
      skid_sat  <= 1'b0;
      skid_frac <= 1'b0;
    end else begin
      if (load_main) begin
        out_int  <= conv_int;
        out_sat  <= conv_sat;
        out_frac <= conv_frac;
      end else if (promote) begin
        out_int  <= skid_int;
        out_sat  <= skid_sat;
        out_frac <= skid_frac;
      end
      if (load_skid) begin
        skid_int  <= conv_int;
        skid_sat  <= conv_sat;
        skid_frac <= conv_frac;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      sat_cnt <= '0;
    else if (clr_cnt)                                sat_cnt <= '0;
    else if (out_xfer && out_sat && (sat_cnt != '1)) sat_cnt <= sat_cnt + CW'(1);
  end

endmodule
